lsu_mem_stage: RTL
==================

Name: lsu_mem_stage

Overview:
- Memory-access stage directly downstream of the integer ALU.
- Takes the effective address and store data computed by the ALU, drives a single-outstanding 64-bit data bus, and returns load data to writeback.
- Performs lane alignment, byte strobes, sign/zero extension, misalignment detection and a response timeout.
- Replaces the ALU's combinational load extension with a registered, handshaked path.

Parameters:
- XLEN, 64, data/address width; only 64 supported.
- TIMEOUT, 255, maximum cycles spent in WAIT_RSP before a bus error is flagged; legal range 1..65535.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  ALU presents a memory op
- req_ready  out  1  stage can accept an op
- req_store  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=double
- req_unsigned  in  1  zero-extend load (LBU/LHU/LWU)
- req_addr  in  XLEN  effective address (rs1+imm)
- req_wdata  in  XLEN  store data, right-justified
- req_rd  in  5  destination register index
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  XLEN  8-byte-aligned address ({req_addr[63:3],3'b0})
- mem_wdata  out  XLEN  lane-shifted store data
- mem_wstrb  out  8  byte enables
- mem_gnt  in  1  bus accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  XLEN  read data, full doubleword
- wb_valid  out  1  one-cycle completion pulse
- wb_we  out  1  register write required (loads only)
- wb_rd  out  5  destination index
- wb_data  out  XLEN  extended load data; 0 for stores/faults
- fault_misalign  out  1  valid with wb_valid
- fault_bus  out  1  valid with wb_valid

Behaviour:
- States: IDLE, REQ, WAIT_RSP, DONE.
- Reset (sync, rst=1 at clock edge):
  - state=IDLE.
  - All outputs 0 except req_ready=1.
  - Timeout counter cleared.
  - Reset mid-transaction abandons it: no wb_valid, mem_req drops next cycle.
- IDLE:
  - req_ready=1. Accept on req_valid.
  - Latch all req_* fields, then evaluate alignment.
  - Misaligned when size=1 and addr[0]!=0, size=2 and addr[1:0]!=0, or size=3 and addr[2:0]!=0.
  - Misaligned op -> DONE with fault_misalign=1, wb_we=0. No bus activity.
  - Aligned op -> REQ.
- REQ:
  - mem_req=1. mem_addr, mem_we, mem_wdata and mem_wstrb are held stable until grant.
  - Strobes: base mask is 0x01, 0x03, 0x0F or 0xFF by size, shifted left by addr[2:0].
  - mem_wdata = req_wdata << (8*addr[2:0]). Only lanes with a set strobe are meaningful.
  - mem_gnt with store -> DONE (wb_we=0).
  - mem_gnt with load -> WAIT_RSP. Counter cleared.
  - A grant is never timed out.
- WAIT_RSP:
  - mem_req=0. Counter increments each cycle.
  - mem_rvalid -> extract: shifted = mem_rdata >> (8*addr[2:0]).
  - Keep the low 8/16/32/64 bits and sign-extend from the top kept bit unless req_unsigned. Size 3 ignores req_unsigned.
  - Result goes to DONE with wb_we=1 (wb_we=0 if rd=0).
  - Counter reaching TIMEOUT without rvalid -> DONE with fault_bus=1, wb_we=0, wb_data=0.
  - rvalid in the same cycle the counter reaches TIMEOUT: data wins, no fault.
- DONE:
  - wb_valid=1 for exactly one cycle with wb_rd, wb_data, wb_we and faults registered.
  - Next state IDLE. req_ready=0 here.
- Latency (accept edge to wb_valid):
  - Store with immediate grant: 2 cycles.
  - Load with immediate grant and next-cycle rvalid: 3 cycles.
  - Misaligned: 1 cycle.
- Stray mem_rvalid outside WAIT_RSP is ignored.
- req_ready=0 outside IDLE. A held req_valid is accepted when IDLE is re-entered.

Test Plan:
- LW, addr=0x1004, req_unsigned=0, gnt immediate, rvalid next cycle with rdata=0x8000_0001_0000_0000 -> mem_addr=0x1000; wb_data=0xFFFF_FFFF_8000_0001, wb_we=1, wb_valid 3 cycles after accept.
- SB, addr=0x2003, wdata=0xAB, gnt held low 4 cycles -> mem_req stable 5 cycles, mem_wstrb=0x08, mem_wdata[31:24]=0xAB; wb_valid with wb_we=0.
- LH, addr=0x3001 -> fault_misalign=1 with wb_valid 1 cycle after accept; mem_req never asserted.
- LBU, addr=0x4007, rdata=0xFE00_..._00 -> wb_data=0x0000_0000_0000_00FE. Repeat as LB -> 0xFFFF_FFFF_FFFF_FFFE.
- LD with TIMEOUT=4 and no rvalid -> fault_bus=1, wb_data=0, wb_we=0. Repeat with rvalid on the 4th wait cycle -> data returned, no fault.
- rst asserted in WAIT_RSP -> next cycle IDLE, req_ready=1, no wb_valid. A later rvalid is ignored; a new request completes normally.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
//   Memory-access stage sitting behind the integer ALU. Accepts one memory
//   op at a time, drives a single-outstanding 64-bit data bus, and returns
//   the aligned, sign/zero-extended load result to writeback as a one-cycle
//   pulse. Misaligned ops fault without touching the bus; a load whose
//   response never arrives faults after TIMEOUT wait cycles.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req_*           op from the ALU (valid/ready handshake); addr is the
//                   effective byte address, wdata is right-justified
//   mem_*           bus request side (req/we/addr/wdata/wstrb, gnt in) and
//                   response side (rvalid/rdata in)
//   wb_*            completion pulse, register write enable, rd, data
//   fault_misalign  misaligned access, valid with wb_valid
//   fault_bus       response timeout, valid with wb_valid
// ---------------------------------------------------------------------------
module lsu_mem_stage #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wstrb,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            fault_misalign,
    output logic            fault_bus
);

    // Last wait cycle index: the counter starts at 0 on the first wait
    // cycle, so the TIMEOUT-th wait cycle sees cnt_q == TIMEOUT-1.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        DONE
    } state_e;

    state_e state_q, state_d;

    // Latched op fields
    logic            store_q, store_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [4:0]      rd_q, rd_d;

    // Completion record presented during DONE
    logic [XLEN-1:0] res_q, res_d;
    logic            we_q, we_d;
    logic            fmis_q, fmis_d;
    logic            fbus_q, fbus_d;

    // Response timeout counter
    logic [15:0]     cnt_q, cnt_d;

    // ---------------------------------------------------------------------
    // Alignment check on the incoming op (evaluated at accept)
    // ---------------------------------------------------------------------
    logic misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0: misaligned = 1'b0;
            2'd1: misaligned = req_addr[0];
            2'd2: misaligned = |req_addr[1:0];
            2'd3: misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Lane alignment for the latched op
    // ---------------------------------------------------------------------
    logic [5:0]      lane_sh;
    logic [7:0]      strb_base;
    logic [XLEN-1:0] rdata_sh;
    logic [XLEN-1:0] load_ext;

    assign lane_sh  = {addr_q[2:0], 3'b000};
    assign rdata_sh = mem_rdata >> lane_sh;

    always_comb begin
        strb_base = 8'h00;
        case (size_q)
            2'd0: strb_base = 8'h01;
            2'd1: strb_base = 8'h03;
            2'd2: strb_base = 8'h0F;
            2'd3: strb_base = 8'hFF;
            default: strb_base = 8'h00;
        endcase
    end

    // Size 3 keeps the whole doubleword, so req_unsigned has no effect there.
    always_comb begin
        load_ext = '0;
        case (size_q)
            2'd0: load_ext = uns_q ? {{(XLEN-8){1'b0}},         rdata_sh[7:0]}
                                   : {{(XLEN-8){rdata_sh[7]}},   rdata_sh[7:0]};
            2'd1: load_ext = uns_q ? {{(XLEN-16){1'b0}},        rdata_sh[15:0]}
                                   : {{(XLEN-16){rdata_sh[15]}}, rdata_sh[15:0]};
            2'd2: load_ext = uns_q ? {{(XLEN-32){1'b0}},        rdata_sh[31:0]}
                                   : {{(XLEN-32){rdata_sh[31]}}, rdata_sh[31:0]};
            2'd3: load_ext = rdata_sh;
            default: load_ext = rdata_sh;
        endcase
    end

    logic wait_expired;
    assign wait_expired = (cnt_q == TMO_LAST);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = misaligned ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = store_q ? DONE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // rvalid on the expiry cycle still counts as a response.
                if (mem_rvalid || wait_expired) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        store_d = store_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        res_d   = res_q;
        we_d    = we_q;
        fmis_d  = fmis_q;
        fbus_d  = fbus_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d = req_store;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    res_d   = '0;
                    we_d    = 1'b0;
                    fmis_d  = misaligned;
                    fbus_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    cnt_d = '0;
                end
            end
            WAIT_RSP: begin
                cnt_d = cnt_q + 16'd1;
                if (mem_rvalid) begin
                    res_d = load_ext;
                    we_d  = (rd_q != 5'd0);
                end else if (wait_expired) begin
                    fbus_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            store_q <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 5'd0;
            res_q   <= '0;
            we_q    <= 1'b0;
            fmis_q  <= 1'b0;
            fbus_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            store_q <= store_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            we_q    <= we_d;
            fmis_q  <= fmis_d;
            fbus_q  <= fbus_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: outputs (bus fields only driven in REQ, writeback only in DONE)
    // ---------------------------------------------------------------------
    always_comb begin
        req_ready      = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_wstrb      = 8'h00;
        wb_valid       = 1'b0;
        wb_we          = 1'b0;
        wb_rd          = 5'd0;
        wb_data        = '0;
        fault_misalign = 1'b0;
        fault_bus      = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
            end
            REQ: begin
                mem_req   = 1'b1;
                mem_we    = store_q;
                mem_addr  = {addr_q[XLEN-1:3], 3'b000};
                mem_wdata = wdata_q << lane_sh;
                mem_wstrb = strb_base << addr_q[2:0];
            end
            DONE: begin
                wb_valid       = 1'b1;
                wb_we          = we_q;
                wb_rd          = rd_q;
                wb_data        = res_q;
                fault_misalign = fmis_q;
                fault_bus      = fbus_q;
            end
            default: begin
            end
        endcase
    end

endmodule
